mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 output multiplexer (2-bit select, active-low enable, high-Z output when disabled) among four requesters.
- Drives the mux select and active-low enable directly.
- Returns a one-hot grant to the winning requester.
- Inserts a one-cycle high-Z turnaround between owners so two sources never drive the shared line in the same cycle.
- Sits between the requesting blocks and the shared mux.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one requester may hold the mux; legal range 1..(2^CNT_W - 1).
CNT_W, 4, width of the internal hold counter.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
req  input  4  request lines; req[i] high = requester i wants the mux
gnt  output  4  one-hot grant; gnt[i] high = requester i's data is routed through the mux
sel  output  2  mux select (b[1:0] of the mux); index of the current or last owner
en_n  output  1  mux enable, active low; 1 = mux output high-Z
busy  output  1  high while any grant is active (state GRANT)

Behaviour:
- Single clock domain. All outputs are registered; no combinational path from req to any output.
- Reset: one clock; reset is asynchronous and active-high. While reset is high, or immediately on its assertion (including mid-grant):
  - state = IDLE, gnt = 4'b0000, sel = 2'b00, en_n = 1, busy = 0.
  - hold counter = 0, last-owner pointer = 3, so requester 0 has first priority after reset.
- States: IDLE, GRANT, TURN.
- Arbitration is evaluated at a rising edge when state is IDLE or TURN:
  - Search order is (last+1), (last+2), (last+3), (last+4), all mod 4.
  - The first index w with req[w]=1 wins.
  - Next state = GRANT, gnt = one-hot(w), sel = w, en_n = 0, busy = 1, counter = 1.
  - If no req is set: next state = IDLE and outputs are unchanged (gnt = 0, en_n = 1, sel holds its previous value).
- Latency: req sampled high at edge N -> gnt/en_n valid after edge N (1 cycle).
- GRANT, evaluated at each edge:
  - If req[w]=0 or counter == HOLD_MAX: release. gnt = 0, en_n = 1, busy = 0, last = w, next state = TURN, counter = 0.
  - Otherwise stay in GRANT with counter + 1.
  - sel is not changed on release.
- Grant length: the owner holds for min(cycles req[w] stays high, HOLD_MAX) cycles. With HOLD_MAX = 1, every grant lasts exactly one cycle.
- Release on req drop: req[w] dropping in the same cycle the counter reaches HOLD_MAX is a single release, not a double event.
- Requests from other indices are ignored during GRANT.
- TURN: lasts exactly one cycle with en_n = 1, then arbitrates exactly as IDLE does.
  - Back-to-back owners are therefore separated by exactly one high-Z cycle.
  - The previous owner has the lowest priority in that arbitration.
- Starvation: with all req held high, every requester is granted within 3*(HOLD_MAX+1) cycles of its request.
- Invariants, checked every cycle:
  - gnt is zero or one-hot.
  - en_n == ~|gnt.
  - busy == |gnt.
  - When gnt != 0, sel == index of gnt.
  - The counter never exceeds HOLD_MAX.
- Out-of-range parameters (HOLD_MAX = 0, or HOLD_MAX >= 2^CNT_W) are illegal and are not supported.

Test Plan:
- Reset check: assert reset mid-grant (gnt = 0100), asynchronously between edges -> gnt = 0000, en_n = 1, sel = 00, busy = 0 before the next edge; after release, req = 1111 -> first gnt = 0001.
- Single requester: req = 0010 for 3 cycles, then 0000 -> gnt = 0010 with sel = 01, en_n = 0 for exactly 3 cycles, then one TURN cycle, then IDLE with en_n = 1.
- Hold limit: HOLD_MAX = 8, req = 1000 held for 20 cycles -> grant pattern is 8 cycles on, 1 cycle off, 8 on, 1 off, ...; counter never exceeds 8.
- Fairness: req = 1111 held -> grant order 0001, 0010, 0100, 1000, 0001, each 8 cycles long with a 1-cycle en_n = 1 gap between grants.
- Priority rotation: owner 2 releases while req = 0101 -> next grant is 0001 (search order 3, 0, 1, 2), not 0100.
- Edge case, HOLD_MAX = 1 with req[3] dropping on its grant cycle -> exactly one 1-cycle grant and one TURN; no glitch on en_n; invariants hold throughout.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter that gives four requesters turns on one shared 4:1
// tri-state output mux. The arbiter drives the mux select and the active-low
// enable itself, and it returns a one-hot grant to the winning requester.
// Between two owners it always inserts one cycle with the mux disabled
// (high-Z), so two sources never drive the shared line in the same cycle.
//
// Parameters
//   HOLD_MAX : maximum consecutive cycles one owner may keep the mux
//              (legal range 1 .. 2**CNT_W-1)
//   CNT_W    : width of the hold counter
//
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  asynchronous active-high reset
//   req    in   4  request lines, req[i] = requester i wants the mux
//   gnt    out  4  one-hot grant (0 when the mux is idle or turning around)
//   sel    out  2  mux select: index of the current or most recent owner
//   en_n   out  1  mux enable, active low (1 = mux output high-Z)
//   busy   out  1  high while a grant is active
//
// Every output comes straight from a flop, so there is no combinational
// path from req to any output.
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       en_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [3:0]       gnt_reg;
    logic [1:0]       sel_reg;
    logic             en_n_reg;
    logic             busy_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic [1:0]       last_reg;

    // Candidate k (0..3) sits k+1 positions after the last owner. The last
    // owner is therefore checked last and has the lowest priority.
    logic [1:0] cand_idx [4];
    logic [3:0] cand_req;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cand
            assign cand_idx[gi] = last_reg + 2'(gi + 1);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Pick the lowest-numbered candidate whose request is set. The loop
    // scans from the highest to the lowest candidate, so the nearest one
    // overwrites the others.
    logic       win_found;
    logic [1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = last_reg;
        for (int k = 3; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
    end

    logic [3:0] win_onehot;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == 2'(gi));
        end
    endgenerate

    // While in GRANT, sel_reg holds the index of the current owner.
    logic owner_req;
    logic hold_done;
    assign owner_req = req[sel_reg];
    assign hold_done = (hold_cnt_reg == CNT_W'(HOLD_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            gnt_reg      <= 4'b0000;
            sel_reg      <= 2'b00;
            en_n_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            hold_cnt_reg <= '0;
            last_reg     <= 2'd3;   // requester 0 is searched first after reset
        end else begin
            case (state_reg)
                IDLE, TURN: begin
                    if (win_found) begin
                        state_reg    <= GRANT;
                        gnt_reg      <= win_onehot;
                        sel_reg      <= win_idx;
                        en_n_reg     <= 1'b0;
                        busy_reg     <= 1'b1;
                        hold_cnt_reg <= CNT_W'(1);
                    end else begin
                        // Nothing to grant: stay idle. sel keeps the last owner.
                        state_reg    <= IDLE;
                        gnt_reg      <= 4'b0000;
                        en_n_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                    end
                end
                GRANT: begin
                    // A dropped request and an expired hold count in the
                    // same cycle are one release, not two.
                    if (!owner_req || hold_done) begin
                        state_reg    <= TURN;
                        gnt_reg      <= 4'b0000;
                        en_n_reg     <= 1'b1;
                        busy_reg     <= 1'b0;
                        last_reg     <= sel_reg;
                        hold_cnt_reg <= '0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    gnt_reg      <= 4'b0000;
                    en_n_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                    hold_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign gnt  = gnt_reg;
    assign sel  = sel_reg;
    assign en_n = en_n_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en_n;
    logic       busy;

    logic [3:0] req1;
    logic [3:0] gnt1;
    logic [1:0] sel1;
    logic       en_n1;
    logic       busy1;

    int compared   = 0;
    int mismatched = 0;
    bit inv_en     = 0;

    mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt), .sel(sel), .en_n(en_n), .busy(busy)
    );

    mux4_rr_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .req(req1),
        .gnt(gnt1), .sel(sel1), .en_n(en_n1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         unit;   // 0: HOLD_MAX=8 instance, 1: HOLD_MAX=1 instance
        logic [3:0] req;
        int         reps;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       en_n;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit u, input logic [3:0] r, input int n,
                       input logic [3:0] g, input logic [1:0] s,
                       input logic e, input logic b);
        vec_t v;
        v.unit = u; v.req = r; v.reps = n;
        v.gnt = g; v.sel = s; v.en_n = e; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Per-cycle invariants for both instances, sampled mid-cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            check("inv_onehot", {3'b0, (gnt & (gnt - 4'd1)) == 4'd0}, 4'd1);
            check("inv_en_n", {3'b0, en_n}, {3'b0, ~|gnt});
            check("inv_busy", {3'b0, busy}, {3'b0, |gnt});
            if (gnt != 4'd0) check("inv_sel", {2'b0, sel}, {2'b0, idx_of(gnt)});
            check("inv_cnt", {3'b0, dut.hold_cnt_reg <= 4'd8}, 4'd1);
            check("inv1_onehot", {3'b0, (gnt1 & (gnt1 - 4'd1)) == 4'd0}, 4'd1);
            check("inv1_en_n", {3'b0, en_n1}, {3'b0, ~|gnt1});
            check("inv1_busy", {3'b0, busy1}, {3'b0, |gnt1});
            if (gnt1 != 4'd0) check("inv1_sel", {2'b0, sel1}, {2'b0, idx_of(gnt1)});
            check("inv1_cnt", {3'b0, dut1.hold_cnt_reg <= 4'd1}, 4'd1);
        end
    end

    initial begin
        // ---------------- vector table ----------------
        // single requester: 3 grant cycles, one TURN, then IDLE
        add(0, 4'b0010, 3, 4'b0010, 2'd1, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 2'd1, 1, 0);
        add(0, 4'b0000, 2, 4'b0000, 2'd1, 1, 0);
        // owner 2 runs to the hold limit with req=0101; next winner is 0
        add(0, 4'b0100, 1, 4'b0100, 2'd2, 0, 1);
        add(0, 4'b0101, 7, 4'b0100, 2'd2, 0, 1);
        add(0, 4'b0101, 1, 4'b0000, 2'd2, 1, 0);
        add(0, 4'b0101, 1, 4'b0001, 2'd0, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 1, 0);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 1, 0);
        // hold limit: req=1000 for 20 cycles -> 8 on, 1 off, 8 on, 1 off, 2 on
        add(0, 4'b1000, 8, 4'b1000, 2'd3, 0, 1);
        add(0, 4'b1000, 1, 4'b0000, 2'd3, 1, 0);
        add(0, 4'b1000, 8, 4'b1000, 2'd3, 0, 1);
        add(0, 4'b1000, 1, 4'b0000, 2'd3, 1, 0);
        add(0, 4'b1000, 2, 4'b1000, 2'd3, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 2'd3, 1, 0);
        add(0, 4'b0000, 1, 4'b0000, 2'd3, 1, 0);
        // fairness: all requesting
        add(0, 4'b1111, 8, 4'b0001, 2'd0, 0, 1);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 1, 0);
        add(0, 4'b1111, 8, 4'b0010, 2'd1, 0, 1);
        add(0, 4'b1111, 1, 4'b0000, 2'd1, 1, 0);
        add(0, 4'b1111, 8, 4'b0100, 2'd2, 0, 1);
        add(0, 4'b1111, 1, 4'b0000, 2'd2, 1, 0);
        add(0, 4'b1111, 8, 4'b1000, 2'd3, 0, 1);
        add(0, 4'b1111, 1, 4'b0000, 2'd3, 1, 0);
        add(0, 4'b1111, 8, 4'b0001, 2'd0, 0, 1);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 1, 0);
        // HOLD_MAX=1: req[3] drops on its grant cycle -> a single release
        add(1, 4'b1000, 1, 4'b1000, 2'd3, 0, 1);
        add(1, 4'b0000, 1, 4'b0000, 2'd3, 1, 0);
        add(1, 4'b0000, 1, 4'b0000, 2'd3, 1, 0);
        // HOLD_MAX=1 with req held: alternating 1 on / 1 off
        add(1, 4'b1000, 1, 4'b1000, 2'd3, 0, 1);
        add(1, 4'b1000, 1, 4'b0000, 2'd3, 1, 0);
        add(1, 4'b1000, 1, 4'b1000, 2'd3, 0, 1);
        add(1, 4'b1000, 1, 4'b0000, 2'd3, 1, 0);
        add(1, 4'b1001, 1, 4'b0001, 2'd0, 0, 1);
        add(1, 4'b1001, 1, 4'b0000, 2'd0, 1, 0);
        add(1, 4'b1001, 1, 4'b1000, 2'd3, 0, 1);
        add(1, 4'b0000, 1, 4'b0000, 2'd3, 1, 0);

        // ---------------- reset ----------------
        req = 4'b0000; req1 = 4'b0000; reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_sel", {2'b0, sel}, 4'd0);
        check("rst_en_n", {3'b0, en_n}, 4'd1);
        check("rst_busy", {3'b0, busy}, 4'd0);
        inv_en = 1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // ---------------- table run ----------------
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                if (vecs[i].unit) req1 = vecs[i].req; else req = vecs[i].req;
                @(posedge clk); #1;
                if (vecs[i].unit) begin
                    check($sformatf("v%0d.%0d gnt1", i, r), gnt1, vecs[i].gnt);
                    check($sformatf("v%0d.%0d sel1", i, r), {2'b0, sel1}, {2'b0, vecs[i].sel});
                    check($sformatf("v%0d.%0d en_n1", i, r), {3'b0, en_n1}, {3'b0, vecs[i].en_n});
                    check($sformatf("v%0d.%0d busy1", i, r), {3'b0, busy1}, {3'b0, vecs[i].busy});
                    $display("vec %0d.%0d u1 req=%b gnt=%b sel=%0d en_n=%b busy=%b",
                             i, r, req1, gnt1, sel1, en_n1, busy1);
                end else begin
                    check($sformatf("v%0d.%0d gnt", i, r), gnt, vecs[i].gnt);
                    check($sformatf("v%0d.%0d sel", i, r), {2'b0, sel}, {2'b0, vecs[i].sel});
                    check($sformatf("v%0d.%0d en_n", i, r), {3'b0, en_n}, {3'b0, vecs[i].en_n});
                    check($sformatf("v%0d.%0d busy", i, r), {3'b0, busy}, {3'b0, vecs[i].busy});
                    $display("vec %0d.%0d u0 req=%b gnt=%b sel=%0d en_n=%b busy=%b",
                             i, r, req, gnt, sel, en_n, busy);
                end
            end
        end

        // ---------------- asynchronous reset mid-grant ----------------
        req = 4'b0100;
        @(posedge clk); #1;
        check("pre_rst_gnt", gnt, 4'b0100);
        #3 reset = 1'b1;
        #1;
        check("async_rst_gnt", gnt, 4'b0000);
        check("async_rst_sel", {2'b0, sel}, 4'd0);
        check("async_rst_en_n", {3'b0, en_n}, 4'd1);
        check("async_rst_busy", {3'b0, busy}, 4'd0);
        $display("async reset mid-grant: gnt=%b sel=%0d en_n=%b busy=%b", gnt, sel, en_n, busy);
        @(posedge clk); #1;
        reset = 1'b0;
        req = 4'b1111;
        @(posedge clk); #1;
        check("post_rst_gnt", gnt, 4'b0001);
        check("post_rst_sel", {2'b0, sel}, 4'd0);
        check("post_rst_en_n", {3'b0, en_n}, 4'd0);
        $display("after reset req=1111: gnt=%b sel=%0d en_n=%b", gnt, sel, en_n);
        req = 4'b0000;
        @(posedge clk); @(posedge clk); #1;
        inv_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
